// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the MLP neuron datapath.
// Holds the neuron FSM state type, activation-mode codes, the tanh
// piecewise-linear tables and a generic round/saturate helper.
package nn_fixed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic ACT_TANSIG = 1'b0;
    localparam logic ACT_LINEAR = 1'b1;

    // Tables are in Q.15; 16 uniform segments of width 0.25 cover |x| < 4.0
    localparam int unsigned PWL_Q        = 15;
    localparam int unsigned PWL_SEG_BITS = 13;
    localparam int unsigned PWL_N        = 16;

    // Segment start points (|x| in Q.15)
    localparam int unsigned PWL_BREAK [PWL_N] = '{
        0,     8192,  16384, 24576, 32768,  40960,  49152,  57344,
        65536, 73728, 81920, 90112, 98304, 106496, 114688, 122880
    };

    // tanh at each segment start (Q.15)
    localparam int unsigned PWL_OFFSET [PWL_N] = '{
        0,     8025,  15143, 20813, 24956, 27797, 29660, 30847,
        31589, 32048, 32330, 32501, 32606, 32669, 32708, 32732
    };

    // Rise of tanh across each segment (Q.15)
    localparam int unsigned PWL_SLOPE [PWL_N] = '{
        8025, 7118, 5670, 4143, 2841, 1863, 1187, 742,
        459,  282,  171,  105,  63,   39,   24,   14
    };

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rs_t;

    // Round-half-up then clamp to a signed out_w-bit range
    function automatic rs_t round_sat(input logic signed [63:0] a,
                                      input int unsigned frac_bits,
                                      input int unsigned out_w);
        rs_t                res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (a + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/tansig_pwl.sv
// Two-stage pipelined odd-symmetric piecewise-linear tanh.
// Ports: clk, rst_n (async active-low), x (signed Qn.FRAC_BITS input),
//        y (signed Qn.FRAC_BITS output, clamped to +/-1.0, two cycles after x).
module tansig_pwl
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int unsigned AX_W = DATA_WIDTH + 1;
    localparam int unsigned AQ_W = PWL_SEG_BITS + 4;
    localparam int unsigned SH   = PWL_Q - FRAC_BITS;
    localparam int unsigned RND  = (32'd1 << SH) >> 1;
    localparam int unsigned ONE  = 32'd1 << FRAC_BITS;
    localparam logic [AX_W-1:0] LIMIT = AX_W'(32'd4 << FRAC_BITS);

    logic signed [AX_W-1:0]   xs;
    logic [AX_W-1:0]          ax;
    logic [AQ_W-1:0]          ax_q;
    logic                     neg_c;
    logic                     big_c;
    logic [3:0]               idx_c;
    logic [PWL_SEG_BITS-1:0]  frac_c;

    logic                     a_neg;
    logic                     a_big;
    logic [3:0]               a_idx;
    logic [PWL_SEG_BITS-1:0]  a_frac;

    logic [31:0]              yq;
    logic [31:0]              yf;
    logic [DATA_WIDTH-1:0]    y_c;

    // Stage A: magnitude, segment index and offset within segment
    always_comb begin
        xs     = AX_W'($signed(x));
        neg_c  = x[DATA_WIDTH-1];
        ax     = neg_c ? AX_W'(-xs) : AX_W'(xs);
        big_c  = (ax >= LIMIT);
        ax_q   = AQ_W'(ax) << SH;
        idx_c  = ax_q[AQ_W-1 -: 4];
        frac_c = PWL_SEG_BITS'(ax_q - AQ_W'(PWL_BREAK[idx_c]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_neg  <= 1'b0;
            a_big  <= 1'b0;
            a_idx  <= '0;
            a_frac <= '0;
        end else begin
            a_neg  <= neg_c;
            a_big  <= big_c;
            a_idx  <= idx_c;
            a_frac <= frac_c;
        end
    end

    // Stage B: interpolate, rescale to output format, restore sign
    always_comb begin
        yq  = PWL_OFFSET[a_idx] + ((PWL_SLOPE[a_idx] * 32'(a_frac)) >> PWL_SEG_BITS);
        yf  = (yq + RND) >> SH;
        if (a_big || (yf > ONE)) begin
            yf = ONE;
        end
        y_c = DATA_WIDTH'(yf);
        if (a_neg) begin
            y_c = -y_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= y_c;
        end
    end

endmodule

// File: rtl/hidden_layer_neuron.sv
// One neuron of the ASR MLP hidden layer.
// Streams N_INPUTS (in_data, in_weight) beats, accumulates products plus bias,
// rounds/saturates, applies tansig or linear activation and offers the result.
// Ports: clk, rst_n; start/bias/act_mode (launch); clear (abort);
//        in_valid/in_ready/in_data/in_weight (input stream);
//        out_valid/out_ready/out_data/out_sat (result); busy.
module hidden_layer_neuron
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 12,
    parameter int unsigned N_INPUTS   = 28,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic                  act_mode,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int unsigned PROD_W       = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W        = $clog2(N_INPUTS + 1);
    localparam int unsigned DRAIN_CYCLES = 4;

    if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(N_INPUTS) + 1) begin : g_acc_width_chk
        $error("ACC_WIDTH too small for DATA_WIDTH and N_INPUTS");
    end
    if (ACC_WIDTH > 63) begin : g_acc_max_chk
        $error("ACC_WIDTH must not exceed 63");
    end
    if (N_INPUTS < 1 || N_INPUTS > 1024) begin : g_n_chk
        $error("N_INPUTS must be in 1..1024");
    end
    if (FRAC_BITS < 1 || FRAC_BITS > PWL_Q || DATA_WIDTH < FRAC_BITS + 4) begin : g_fmt_chk
        $error("Unsupported DATA_WIDTH/FRAC_BITS combination");
    end

    state_t                       state;
    state_t                       state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic [2:0]                   dcnt;
    logic                         mode;
    logic                         accept;
    logic                         last_beat;

    logic signed [PROD_W-1:0]     prod;
    logic                         p_vld;
    logic signed [ACC_WIDTH-1:0]  acc;
    rs_t                          rs_c;
    logic [DATA_WIDTH-1:0]        rs_q;
    logic                         rs_sat;
    logic [DATA_WIDTH-1:0]        lin_d1;
    logic [DATA_WIDTH-1:0]        lin_d2;
    logic                         sat_d1;
    logic                         sat_d2;
    logic [DATA_WIDTH-1:0]        tan_y;

    logic                         in_ready_nxt;
    logic                         busy_nxt;
    logic                         out_valid_nxt;
    logic                         load_out;

    assign accept    = in_valid & in_ready;
    assign last_beat = accept && (cnt == CNT_W'(N_INPUTS - 1));
    assign rs_c      = round_sat(64'(acc), FRAC_BITS, DATA_WIDTH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                       state_nxt = ACC;
            ACC:     if (last_beat)                   state_nxt = DRAIN;
            DRAIN:   if (dcnt == 3'(DRAIN_CYCLES))    state_nxt = OUT;
            OUT:     if (out_valid && out_ready)      state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // Output decode from the upcoming state so handshake flags are registered
    always_comb begin
        in_ready_nxt  = (state_nxt == ACC);
        busy_nxt      = (state_nxt != IDLE);
        out_valid_nxt = (state_nxt == OUT);
        load_out      = (state == DRAIN) && (state_nxt == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
            out_valid <= out_valid_nxt;
            if (load_out) begin
                out_data <= (mode == ACT_LINEAR) ? lin_d2 : tan_y;
                out_sat  <= sat_d2;
            end
        end
    end

    // Multiply / accumulate / round pipeline; linear path delayed to match tansig
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dcnt   <= '0;
            mode   <= ACT_TANSIG;
            prod   <= '0;
            p_vld  <= 1'b0;
            acc    <= '0;
            rs_q   <= '0;
            rs_sat <= 1'b0;
            lin_d1 <= '0;
            lin_d2 <= '0;
            sat_d1 <= 1'b0;
            sat_d2 <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            dcnt   <= '0;
            prod   <= '0;
            p_vld  <= 1'b0;
            acc    <= '0;
            rs_q   <= '0;
            rs_sat <= 1'b0;
            lin_d1 <= '0;
            lin_d2 <= '0;
            sat_d1 <= 1'b0;
            sat_d2 <= 1'b0;
        end else begin
            dcnt <= (state == DRAIN) ? dcnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                acc   <= ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;
                cnt   <= '0;
                p_vld <= 1'b0;
                mode  <= act_mode;
            end else begin
                p_vld <= accept;
                if (accept) begin
                    prod <= PROD_W'($signed(in_data)) * PROD_W'($signed(in_weight));
                    cnt  <= cnt + CNT_W'(1);
                end
                if (p_vld) begin
                    acc <= acc + ACC_WIDTH'(prod);
                end
            end
            rs_q   <= DATA_WIDTH'(rs_c.val);
            rs_sat <= rs_c.sat;
            lin_d1 <= rs_q;
            lin_d2 <= lin_d1;
            sat_d1 <= rs_sat;
            sat_d2 <= sat_d1;
        end
    end

    tansig_pwl #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_tansig (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (rs_q),
        .y     (tan_y)
    );

endmodule

// File: doc/hidden_layer_neuron.md
Name: hidden_layer_neuron

Overview:
- Parametrised successor of the single hidden neuron: one neuron of the ASR MLP hidden layer.
- Accepts a start and bias, then streams N_INPUTS (input, weight) pairs under a valid/ready handshake, accumulating their products with the bias.
- Rounds and saturates the sum, applies a run-time-selectable activation (tansig or linear bypass), and holds the result under a valid/ready output handshake.
- Sits between the feature-vector sequencer and the output-layer neurons; replaces fixed 32-bit, fixed-28-input, dual-clock operation.

Parameters:
- DATA_WIDTH, 16, signed fixed-point width of inputs, weights, bias and output.
- FRAC_BITS, 12, fractional bits of all data (Q4.12 at default; 1.0 = 4096).
- N_INPUTS, 28, number of products per neuron evaluation. Range 1..1024.
- ACC_WIDTH, 40, accumulator width. Elaboration error if less than 2*DATA_WIDTH+clog2(N_INPUTS)+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin evaluation; sampled only in IDLE
- bias  in  DATA_WIDTH  bias, captured on accepted start
- act_mode  in  1  0 = tansig, 1 = linear; captured on accepted start
- clear  in  1  synchronous abort
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in ACC state
- in_data  in  DATA_WIDTH  neuron input sample
- in_weight  in  DATA_WIDTH  matching weight
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  activated result
- out_sat  out  1  pre-activation saturation occurred for this result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all pipeline registers, beat counter and outputs cleared. in_ready, out_valid, out_sat, busy and out_data all 0.
- FSM states: IDLE -> ACC -> DRAIN -> OUT -> IDLE.
- IDLE: start=1 captures bias and act_mode, clears the accumulator and beat counter, and moves to ACC.
- ACC: in_ready=1. A beat is accepted when in_valid & in_ready.
  - Stage 1 registers the signed product in_data*in_weight (2*DATA_WIDTH bits).
  - Stage 2 adds the sign-extended product to the accumulator.
  - The accumulator is preloaded with bias<<FRAC_BITS.
  - Gaps in in_valid stall the counter only.
  - The N_INPUTS-th accepted beat moves the FSM to DRAIN.
- DRAIN (pipeline only, in_ready=0):
  - Round: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat is set if clamping occurred.
  - Activation takes 2 cycles in both modes; linear mode is delayed to match.
- Latency: last beat accepted at edge k gives out_valid=1 after edge k+5.
- OUT:
  - out_valid, out_data and out_sat are held stable until out_valid & out_ready.
  - On that edge out_valid drops and the FSM returns to IDLE; out_data and out_sat keep their last value.
  - start in the same cycle is ignored; it is sampled next cycle in IDLE.
- start outside IDLE is ignored (no queuing).
- clear in any state:
  - Next edge forces IDLE, drops out_valid and in_ready, and flushes the pipeline and counter.
  - clear and start in the same cycle: clear wins.
- Tansig:
  - Odd-symmetric 16-segment piecewise-linear approximation of tanh over |x| < 4.0.
  - |x| >= 4.0 gives exactly ±1.0, i.e. ±(1<<FRAC_BITS); x = 0 gives exactly 0.
  - Maximum error vs. real tanh is 2^-7 in the interior.
  - Output is clamped to ±1.0.
- Accumulator cannot overflow given the ACC_WIDTH rule; no wrap-around path exists.

Decomposition:
- Shared package nn_fixed_pkg holds:
  - state enum (IDLE, ACC, DRAIN, OUT);
  - the ACT_TANSIG / ACT_LINEAR constants;
  - the PWL breakpoint, slope and offset constant tables;
  - a round/saturate function parametrised by widths.
- One sub-module, tansig_pwl: 2-stage pipelined activation with ports clk, rst_n, x, y.

Test Plan (N_INPUTS=4, default widths):
- Reset asserted mid-ACC after 2 beats -> all outputs 0, FSM IDLE. Fresh run after release gives the correct, uncontaminated result.
- Linear mode, bias 0, four beats in_data=4096, in_weight=1024 back-to-back -> out_data=4096, out_sat=0, out_valid exactly 5 cycles after the 4th beat.
- Linear mode, four beats 7.0×7.0 (28672×28672) -> out_data=0x7FFF, out_sat=1. Same with weight -7.0 -> 0x8000, out_sat=1.
- Tansig mode:
  - bias 0, inputs 0 -> out_data=0;
  - bias 0x4000 (4.0), inputs 0 -> 4096;
  - bias 0xC000 (-4.0), inputs 0 -> 0xF000.
- in_valid toggling 1/0 plus out_ready held low 10 cycles:
  - counter advances only on accepted beats;
  - out_data stays stable while waiting;
  - start pulses during OUT are ignored, with busy=1 and in_ready=0.
- clear after 2 beats, then new start with bias 4096 and four zero beats -> linear result 4096. clear and start in the same IDLE cycle -> stays IDLE.
